// File: rtl/tile_load_sequencer.sv
// Tile load sequencer: streams host words into kernel memory (once per run), then input
// memory and overlap cache for each tile, handing each resident tile to the compute FSM.
module tile_load_sequencer #(
    parameter int IO_DATA_WIDTH = 16,
    parameter int TILE_W        = 64,
    parameter int TILE_H        = 128,
    parameter int TILE_IN_CH    = 2,
    parameter int TILE_OUT_CH   = 16,
    parameter int KERNEL_SIZE   = 3,
    parameter int NB_TILES      = 16
) (
    input  logic                        clk,
    input  logic                        rst_in,
    input  logic                        start,
    input  logic [IO_DATA_WIDTH-1:0]    s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic [15:0]                 wr_addr,
    output logic [IO_DATA_WIDTH-1:0]    wr_data,
    output logic                        int_mem_we,
    output logic                        overlap_cache_we,
    output logic                        data_ready,
    input  logic                        fsm_done,
    output logic [$clog2(NB_TILES)-1:0] tile_idx,
    output logic                        busy,
    output logic                        run_done
);
    localparam int TW = $clog2(NB_TILES);

    localparam logic [3:0]    OUTCH_LAST = 4'(TILE_OUT_CH - 1);
    localparam logic [1:0]    K_LAST     = 2'(KERNEL_SIZE - 1);
    localparam logic [5:0]    X_LAST     = 6'(TILE_W - 1);
    localparam logic [6:0]    Y_LAST     = 7'(TILE_H - 1);
    localparam logic [0:0]    INCH_LAST  = 1'(TILE_IN_CH - 1);
    localparam logic [TW-1:0] TILE_LAST  = TW'(NB_TILES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LD_KERNEL, S_LD_INPUT, S_LD_OVERLAP, S_FLUSH, S_WAIT_CMP, S_FIN
    } state_t;

    state_t                   state_q, state_d;
    logic                     s_ready_q, s_ready_d;
    logic [15:0]              wr_addr_q, wr_addr_d;
    logic [IO_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                     int_mem_we_q, int_mem_we_d;
    logic                     overlap_cache_we_q, overlap_cache_we_d;
    logic                     data_ready_q, data_ready_d;
    logic                     busy_q, busy_d;
    logic                     run_done_q, run_done_d;
    logic [TW-1:0]            tile_idx_q, tile_idx_d;
    logic [3:0]               outch_q, outch_d;
    logic [1:0]               kx_q, kx_d, ky_q, ky_d;
    logic [5:0]               x_q, x_d;
    logic [6:0]               y_q, y_d;
    logic [0:0]               inch_q, inch_d;
    logic                     beat;

    always_comb begin
        state_d            = state_q;
        wr_addr_d          = wr_addr_q;
        wr_data_d          = wr_data_q;
        int_mem_we_d       = 1'b0;
        overlap_cache_we_d = 1'b0;
        tile_idx_d         = tile_idx_q;
        outch_d            = outch_q;
        kx_d               = kx_q;
        ky_d               = ky_q;
        x_d                = x_q;
        y_d                = y_q;
        inch_d             = inch_q;
        beat               = s_valid & s_ready_q;

        if (beat) begin
            wr_data_d = s_data;
        end

        case (state_q)
            S_IDLE: begin
                outch_d    = '0;
                kx_d       = '0;
                ky_d       = '0;
                x_d        = '0;
                y_d        = '0;
                inch_d     = '0;
                tile_idx_d = '0;
                if (start) state_d = S_LD_KERNEL;
            end
            S_LD_KERNEL: if (beat) begin
                wr_addr_d    = {1'b1, 6'b0, inch_q, ky_q, kx_q, outch_q};
                int_mem_we_d = 1'b1;
                // kx/ky wrap at KERNEL_SIZE-1, so the unused field code 3 never appears
                if (outch_q != OUTCH_LAST) outch_d = outch_q + 4'd1;
                else begin
                    outch_d = '0;
                    if (kx_q != K_LAST) kx_d = kx_q + 2'd1;
                    else begin
                        kx_d = '0;
                        if (ky_q != K_LAST) ky_d = ky_q + 2'd1;
                        else begin
                            ky_d = '0;
                            if (inch_q != INCH_LAST) inch_d = inch_q + 1'b1;
                            else begin
                                inch_d  = '0;
                                state_d = S_LD_INPUT;
                            end
                        end
                    end
                end
            end
            S_LD_INPUT: if (beat) begin
                wr_addr_d    = {2'b0, inch_q, y_q, x_q};
                int_mem_we_d = 1'b1;
                if (x_q != X_LAST) x_d = x_q + 6'd1;
                else begin
                    x_d = '0;
                    if (y_q != Y_LAST) y_d = y_q + 7'd1;
                    else begin
                        y_d = '0;
                        if (inch_q != INCH_LAST) inch_d = inch_q + 1'b1;
                        else begin
                            inch_d  = '0;
                            state_d = S_LD_OVERLAP;
                        end
                    end
                end
            end
            S_LD_OVERLAP: if (beat) begin
                wr_addr_d          = {8'b0, inch_q, y_q};
                overlap_cache_we_d = 1'b1;
                if (y_q != Y_LAST) y_d = y_q + 7'd1;
                else begin
                    y_d = '0;
                    if (inch_q != INCH_LAST) inch_d = inch_q + 1'b1;
                    else begin
                        inch_d  = '0;
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: state_d = S_WAIT_CMP;
            S_WAIT_CMP: if (fsm_done) begin
                if (tile_idx_q < TILE_LAST) begin
                    tile_idx_d = tile_idx_q + 1'b1;
                    state_d    = S_LD_INPUT;
                end else begin
                    state_d = S_FIN;
                end
            end
            S_FIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered from the next state so they line up with it.
        s_ready_d    = (state_d == S_LD_KERNEL) || (state_d == S_LD_INPUT) ||
                       (state_d == S_LD_OVERLAP);
        data_ready_d = (state_d == S_WAIT_CMP);
        busy_d       = (state_d != S_IDLE);
        run_done_d   = (state_d == S_FIN);
        if (state_d == S_IDLE) tile_idx_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q            <= S_IDLE;
            s_ready_q          <= 1'b0;
            wr_addr_q          <= '0;
            wr_data_q          <= '0;
            int_mem_we_q       <= 1'b0;
            overlap_cache_we_q <= 1'b0;
            data_ready_q       <= 1'b0;
            busy_q             <= 1'b0;
            run_done_q         <= 1'b0;
            tile_idx_q         <= '0;
            outch_q            <= '0;
            kx_q               <= '0;
            ky_q               <= '0;
            x_q                <= '0;
            y_q                <= '0;
            inch_q             <= '0;
        end else begin
            state_q            <= state_d;
            s_ready_q          <= s_ready_d;
            wr_addr_q          <= wr_addr_d;
            wr_data_q          <= wr_data_d;
            int_mem_we_q       <= int_mem_we_d;
            overlap_cache_we_q <= overlap_cache_we_d;
            data_ready_q       <= data_ready_d;
            busy_q             <= busy_d;
            run_done_q         <= run_done_d;
            tile_idx_q         <= tile_idx_d;
            outch_q            <= outch_d;
            kx_q               <= kx_d;
            ky_q               <= ky_d;
            x_q                <= x_d;
            y_q                <= y_d;
            inch_q             <= inch_d;
        end
    end

    assign s_ready          = s_ready_q;
    assign wr_addr          = wr_addr_q;
    assign wr_data          = wr_data_q;
    assign int_mem_we       = int_mem_we_q;
    assign overlap_cache_we = overlap_cache_we_q;
    assign data_ready       = data_ready_q;
    assign busy             = busy_q;
    assign run_done         = run_done_q;
    assign tile_idx         = tile_idx_q;

endmodule

// File: tb/tb_tile_load_sequencer.sv
// Bench for tile_load_sequencer (two tiles per run): arithmetic reference model checked
// every cycle, an address table over a logged run, and directed corner-case sequences.
module tb_tile_load_sequencer;
    localparam int NBT  = 2;
    localparam int KLEN = 288;
    localparam int ILEN = 16384;
    localparam int OLEN = 256;
    localparam int TLEN = ILEN + OLEN;
    localparam int P_IDLE = 0, P_LOAD = 1, P_FLUSH = 2, P_WAIT = 3, P_FIN = 4;

    logic        clk = 1'b0;
    logic        rst_in, start, s_valid, fsm_done;
    logic [15:0] s_data;
    logic        s_ready, int_mem_we, overlap_cache_we, data_ready, busy, run_done;
    logic [15:0] wr_addr, wr_data;
    logic [0:0]  tile_idx;

    always #5 clk = ~clk;

    tile_load_sequencer #(.NB_TILES(NBT)) dut (
        .clk(clk), .rst_in(rst_in), .start(start), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .wr_addr(wr_addr), .wr_data(wr_data), .int_mem_we(int_mem_we),
        .overlap_cache_we(overlap_cache_we), .data_ready(data_ready), .fsm_done(fsm_done),
        .tile_idx(tile_idx), .busy(busy), .run_done(run_done)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_phase = P_IDLE, m_pos = 0, m_tile = 0;
    bit         e_ready = 0, e_we = 0, e_ov = 0, e_dr = 0, e_busy = 0, e_done = 0, ov_b;
    logic [0:0] e_tile = '0;
    logic [15:0] e_addr = '0, e_data = '0;

    function automatic logic [15:0] ref_addr(input int tile, input int pos, output bit ov);
        int k, p;
        ov = 0;
        if (tile == 0 && pos < KLEN) begin
            k = pos;
            return 16'h8000 | 16'(((k / 144) << 8) | (((k / 48) % 3) << 6) |
                                  (((k / 16) % 3) << 4) | (k % 16));
        end
        p = (tile == 0) ? pos - KLEN : pos;
        if (p < ILEN) return 16'(p);
        ov = 1;
        return 16'(p - ILEN);
    endfunction

    function automatic int load_len(input int tile);
        return (tile == 0) ? KLEN + TLEN : TLEN;
    endfunction

    always @(posedge clk) begin
        if (rst_in) begin
            m_phase = P_IDLE; m_pos = 0; m_tile = 0; e_we = 0; e_ov = 0;
        end else begin
            e_we = 0; e_ov = 0;
            case (m_phase)
                P_IDLE: if (start) begin m_phase = P_LOAD; m_pos = 0; m_tile = 0; end
                P_LOAD: if (s_valid) begin
                    e_addr = ref_addr(m_tile, m_pos, ov_b);
                    e_ov = ov_b; e_we = !ov_b; e_data = s_data;
                    m_pos++;
                    if (m_pos == load_len(m_tile)) m_phase = P_FLUSH;
                end
                P_FLUSH: m_phase = P_WAIT;
                P_WAIT: if (fsm_done) begin
                    if (m_tile < NBT - 1) begin m_tile++; m_pos = 0; m_phase = P_LOAD; end
                    else m_phase = P_FIN;
                end
                default: m_phase = P_IDLE;
            endcase
        end
        e_ready = (m_phase == P_LOAD);
        e_busy  = (m_phase != P_IDLE);
        e_dr    = (m_phase == P_WAIT);
        e_done  = (m_phase == P_FIN);
        e_tile  = (m_phase == P_IDLE) ? 1'b0 : 1'(m_tile);
    end

    // ---------------- per-cycle monitor ----------------
    typedef struct packed { logic [15:0] addr; logic we; logic ov; } wl_t;
    wl_t wlog[$];
    bit  chk_en = 0, log_en = 0, bub_en = 0;
    int  kcnt = 0, kbad = 0;

    always @(negedge clk) if (chk_en) begin
        chk("cycle", {s_ready, int_mem_we, overlap_cache_we, data_ready, busy, run_done, tile_idx,
                      (e_we | e_ov) ? {wr_addr, wr_data} : 32'h0},
                     {e_ready, e_we, e_ov, e_dr, e_busy, e_done, e_tile,
                      (e_we | e_ov) ? {e_addr, e_data} : 32'h0});
        if (log_en && (int_mem_we || overlap_cache_we))
            wlog.push_back({wr_addr, int_mem_we, overlap_cache_we});
        if (bub_en && int_mem_we && wr_addr[15]) begin
            kcnt++;
            if (wr_addr[7:6] == 2'd3 || wr_addr[5:4] == 2'd3) kbad++;
        end
    end

    // ---------------- stimulus ----------------
    bit vld_hold = 0, bubble = 0;
    always @(negedge clk) begin
        s_data  = 16'($urandom);
        s_valid = bubble ? ($urandom_range(0, 9) >= 3) : vld_hold;
    end

    function automatic logic [63:0] all_outs();
        return {s_ready, int_mem_we, overlap_cache_we, data_ready, busy, run_done, tile_idx,
                wr_addr, wr_data};
    endfunction

    task automatic wait_pos(input int target, input int budget, input string name);
        int n = 0;
        while (!(m_phase == P_LOAD && m_pos >= target) && n < budget) begin
            @(negedge clk); n++;
        end
        chk(name, 64'(n < budget), 64'd1);
    endtask

    task automatic wait_phase(input int ph, input int budget, input string name);
        int n = 0;
        while (m_phase != ph && n < budget) begin
            @(negedge clk); n++;
        end
        chk(name, 64'(n < budget), 64'd1);
    endtask

    task automatic pulse_done();
        fsm_done = 1'b1; @(negedge clk); fsm_done = 1'b0;
    endtask

    typedef struct { int idx; logic [15:0] addr; logic we; logic ov; } vec_t;
    vec_t vecs[18];

    initial begin
        vecs[0]  = '{0,     16'h8000, 1'b1, 1'b0};
        vecs[1]  = '{1,     16'h8001, 1'b1, 1'b0};
        vecs[2]  = '{15,    16'h800F, 1'b1, 1'b0};
        vecs[3]  = '{16,    16'h8010, 1'b1, 1'b0};
        vecs[4]  = '{48,    16'h8040, 1'b1, 1'b0};
        vecs[5]  = '{143,   16'h80AF, 1'b1, 1'b0};
        vecs[6]  = '{144,   16'h8100, 1'b1, 1'b0};
        vecs[7]  = '{287,   16'h81AF, 1'b1, 1'b0};
        vecs[8]  = '{288,   16'h0000, 1'b1, 1'b0};
        vecs[9]  = '{351,   16'h003F, 1'b1, 1'b0};
        vecs[10] = '{352,   16'h0040, 1'b1, 1'b0};
        vecs[11] = '{8480,  16'h2000, 1'b1, 1'b0};
        vecs[12] = '{16671, 16'h3FFF, 1'b1, 1'b0};
        vecs[13] = '{16672, 16'h0000, 1'b0, 1'b1};
        vecs[14] = '{16800, 16'h0080, 1'b0, 1'b1};
        vecs[15] = '{16927, 16'h00FF, 1'b0, 1'b1};
        vecs[16] = '{16928, 16'h0000, 1'b1, 1'b0};
        vecs[17] = '{33567, 16'h00FF, 1'b0, 1'b1};

        rst_in = 1'b1; start = 1'b0; fsm_done = 1'b0; s_valid = 1'b0; s_data = '0;
        repeat (3) @(negedge clk);
        chk_en = 1;
        chk("reset_outputs", all_outs(), 64'h0);
        rst_in = 1'b0;

        // stray fsm_done in IDLE
        pulse_done();
        @(negedge clk);
        chk("idle_stray_done", {busy, s_ready, 1'(tile_idx)}, 3'b000);

        // run 1: continuous valid, two tiles
        vld_hold = 1; log_en = 1;
        start = 1'b1; @(negedge clk); start = 1'b0;
        chk("first_cycle_no_strobe", {s_ready, int_mem_we, busy}, 3'b101);
        @(negedge clk);
        chk("first_strobe", {int_mem_we, overlap_cache_we, wr_addr}, {2'b10, 16'h8000});

        wait_pos(KLEN + 500, 2000, "wait_input500");
        pulse_done();
        wait_pos(KLEN + ILEN + 100, 20000, "wait_overlap100");
        start = 1'b1; @(negedge clk); start = 1'b0;

        wait_phase(P_FLUSH, 2000, "wait_flush_t0");
        chk("last_overlap_t0", {data_ready, s_ready, overlap_cache_we, wr_addr},
            {3'b001, 16'h00FF});
        @(negedge clk);
        chk("data_ready_rise_t0", {data_ready, s_ready, int_mem_we, overlap_cache_we}, 4'b1000);
        repeat (5) begin
            @(negedge clk);
            chk("wait_cmp_idle", {data_ready, s_ready, int_mem_we, overlap_cache_we}, 4'b1000);
        end
        pulse_done();
        chk("tile1_start", {data_ready, s_ready, 1'(tile_idx)}, 3'b011);

        wait_phase(P_FLUSH, 20000, "wait_flush_t1");
        @(negedge clk);
        chk("data_ready_rise_t1", {data_ready, 1'(tile_idx)}, 2'b11);
        repeat (5) @(negedge clk);
        pulse_done();
        chk("run_done_pulse", {run_done, busy, data_ready, 1'(tile_idx)}, 4'b1101);
        @(negedge clk);
        chk("run_end_idle", {run_done, busy, 1'(tile_idx)}, 3'b000);
        vld_hold = 0; log_en = 0;

        chk("log_size", 64'(wlog.size()), 64'(KLEN + NBT * TLEN));
        for (int i = 0; i < 18; i++) begin
            chk($sformatf("addr_vec%0d", vecs[i].idx),
                (vecs[i].idx < wlog.size()) ? 64'(wlog[vecs[i].idx]) : 64'hFFFF_FFFF,
                64'({vecs[i].addr, vecs[i].we, vecs[i].ov}));
        end

        // run 2: bubbles through kernel, reset at input beat 1000
        bubble = 1; bub_en = 1;
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_pos(KLEN + 1000, 5000, "wait_input1000");
        rst_in = 1'b1; @(negedge clk); rst_in = 1'b0;
        chk("reset_mid_input", all_outs(), 64'h0);
        bub_en = 0; bubble = 0;
        chk("kernel_strobes", 64'(kcnt), 64'(KLEN));
        chk("kxky_no_3", 64'(kbad), 64'd0);

        // run 3: restart after reset
        vld_hold = 1;
        start = 1'b1; @(negedge clk); start = 1'b0;
        @(negedge clk);
        chk("restart_addr", {int_mem_we, wr_addr}, {1'b1, 16'h8000});
        repeat (20) @(negedge clk);
        rst_in = 1'b1; @(negedge clk); rst_in = 1'b0; vld_hold = 0;
        @(negedge clk);
        chk_en = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
